// File: rtl/cond_stage.sv
// Execute-stage conditional-execution unit: holds the E pipeline register,
// evaluates the condition field against the architectural flags and gates control.
module cond_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             valid_d,
    input  logic [3:0]       cond_d,
    input  logic [1:0]       flagw_d,
    input  logic             pcs_d,
    input  logic             regw_d,
    input  logic             memw_d,
    input  logic             nowrite_d,
    input  logic [3:0]       alu_flags_e,
    output logic             pcsrc_e,
    output logic             regwrite_e,
    output logic             memwrite_e,
    output logic             cond_ex_e,
    output logic             flush_req,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] annul_cnt
);

    typedef struct packed {
        logic       valid;
        logic [3:0] cond;
        logic [1:0] flagw;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       nowrite;
    } e_reg_t;

    e_reg_t e_q;
    e_reg_t e_next;
    logic   cond_pass;
    logic   n, z, c, v;

    assign {n, z, c, v} = flags_q;

    always_comb begin
        // NOTE: default first so every path assigns cond_pass; no latch is inferred.
        cond_pass = 1'b0;
        case (e_q.cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = !c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = c && !z;
            4'b1001: cond_pass = !c || z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z && (n == v);
            4'b1101: cond_pass = z || (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    assign cond_ex_e  = e_q.valid & cond_pass;
    assign pcsrc_e    = cond_ex_e & e_q.pcs;
    assign regwrite_e = cond_ex_e & e_q.regw & ~e_q.nowrite;
    assign memwrite_e = cond_ex_e & e_q.memw;
    assign flush_req  = pcsrc_e;

    always_comb begin
        e_next = '{valid: valid_d, cond: cond_d, flagw: flagw_d, pcs: pcs_d,
                   regw: regw_d, memw: memw_d, nowrite: nowrite_d};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q       <= '0;
            flags_q   <= 4'b0000;
            annul_cnt <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every update sees pre-edge state.
            // Stall freezes architectural state; an instruction completes exactly once.
            if (!stall) begin
                if (cond_ex_e && e_q.flagw[1]) flags_q[3:2] <= alu_flags_e[3:2];
                if (cond_ex_e && e_q.flagw[0]) flags_q[1:0] <= alu_flags_e[1:0];
                if (e_q.valid && !cond_pass && (annul_cnt != '1))
                    annul_cnt <= annul_cnt + 1'b1;
            end

            // Kill beats hold: a taken branch or external flush always inserts a bubble.
            if (flush || flush_req)
                e_q <= '0;
            else if (!stall)
                e_q <= e_next;
        end
    end

endmodule

// File: tb/tb_cond_stage.sv
// Directed self-checking bench for cond_stage; a narrow-counter twin shares the
// stimulus so counter saturation is reached in a few cycles.
module tb_cond_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, valid_d;
    logic [3:0]  cond_d;
    logic [1:0]  flagw_d;
    logic        pcs_d, regw_d, memw_d, nowrite_d;
    logic [3:0]  alu_flags_e;

    logic        pcsrc_e, regwrite_e, memwrite_e, cond_ex_e, flush_req;
    logic [3:0]  flags_q;
    logic [15:0] annul_cnt;

    logic        s_pcsrc_e, s_regwrite_e, s_memwrite_e, s_cond_ex_e, s_flush_req;
    logic [3:0]  s_flags_q;
    logic [3:0]  s_annul_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cond_stage #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_d(valid_d),
        .cond_d(cond_d), .flagw_d(flagw_d), .pcs_d(pcs_d), .regw_d(regw_d),
        .memw_d(memw_d), .nowrite_d(nowrite_d), .alu_flags_e(alu_flags_e),
        .pcsrc_e(pcsrc_e), .regwrite_e(regwrite_e), .memwrite_e(memwrite_e),
        .cond_ex_e(cond_ex_e), .flush_req(flush_req), .flags_q(flags_q),
        .annul_cnt(annul_cnt)
    );

    cond_stage #(.CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_d(valid_d),
        .cond_d(cond_d), .flagw_d(flagw_d), .pcs_d(pcs_d), .regw_d(regw_d),
        .memw_d(memw_d), .nowrite_d(nowrite_d), .alu_flags_e(alu_flags_e),
        .pcsrc_e(s_pcsrc_e), .regwrite_e(s_regwrite_e), .memwrite_e(s_memwrite_e),
        .cond_ex_e(s_cond_ex_e), .flush_req(s_flush_req), .flags_q(s_flags_q),
        .annul_cnt(s_annul_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] cnd, input logic [1:0] fw,
                         input logic p, input logic r, input logic m, input logic nw);
        valid_d = v; cond_d = cnd; flagw_d = fw;
        pcs_d = p; regw_d = r; memw_d = m; nowrite_d = nw;
    endtask

    task automatic bubble_d();
        drive(1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; alu_flags_e = 4'h0;
        bubble_d();
        step();
        step();
        check("rst_flags", {28'd0, flags_q}, 32'h0);
        check("rst_cnt", {16'd0, annul_cnt}, 32'h0);
        check("rst_outs", {27'd0, pcsrc_e, regwrite_e, memwrite_e, cond_ex_e, flush_req}, 32'h0);
        reset = 1'b0;

        // AL ADDS with ALU flags Z=1
        drive(1'b1, 4'hE, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        alu_flags_e = 4'b0100;
        check("adds_regwrite", {31'd0, regwrite_e}, 32'd1);
        check("adds_flags_before", {28'd0, flags_q}, 32'h0);

        // EQ STR passes on Z=1
        drive(1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        alu_flags_e = 4'b0000;
        check("adds_flags_after", {28'd0, flags_q}, 32'h4);
        check("eq_str_memwrite", {31'd0, memwrite_e}, 32'd1);

        // NE STR fails on Z=1
        drive(1'b1, 4'h1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        check("ne_str_memwrite", {31'd0, memwrite_e}, 32'd0);
        check("ne_str_cnt_before", {16'd0, annul_cnt}, 32'd0);

        // CMP: sets N, never writes a register
        drive(1'b1, 4'hE, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        alu_flags_e = 4'b1000;
        check("ne_str_cnt_after", {16'd0, annul_cnt}, 32'd1);
        check("cmp_regwrite", {31'd0, regwrite_e}, 32'd0);
        check("cmp_cond_ex", {31'd0, cond_ex_e}, 32'd1);

        // LT ADD passes with N=1, V=0
        drive(1'b1, 4'hB, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        alu_flags_e = 4'b0000;
        check("cmp_flags", {28'd0, flags_q}, 32'h8);
        check("lt_cond_ex", {31'd0, cond_ex_e}, 32'd1);
        check("lt_regwrite", {31'd0, regwrite_e}, 32'd1);

        // GE fails with N!=V
        drive(1'b1, 4'hA, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("ge_cond_ex", {31'd0, cond_ex_e}, 32'd0);

        // LS passes with C=0
        drive(1'b1, 4'h9, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("ge_cnt", {16'd0, annul_cnt}, 32'd2);
        check("ls_cond_ex", {31'd0, cond_ex_e}, 32'd1);

        // AL B, then stall with a valid instruction waiting: bubble still loads
        drive(1'b1, 4'hE, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("b_pcsrc", {31'd0, pcsrc_e}, 32'd1);
        check("b_flush_req", {31'd0, flush_req}, 32'd1);
        drive(1'b1, 4'hE, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        stall = 1'b1;
        step();
        check("b_next_bubble", {30'd0, cond_ex_e, flush_req}, 32'd0);
        check("b_next_memwrite", {31'd0, memwrite_e}, 32'd0);
        stall = 1'b0;

        // AL ADDS held in E for three stalled cycles
        drive(1'b1, 4'hE, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        alu_flags_e = 4'b0011;
        stall = 1'b1;
        drive(1'b1, 4'hF, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_flags", {28'd0, flags_q}, 32'h8);
            check("stall_outs", {27'd0, pcsrc_e, regwrite_e, memwrite_e, cond_ex_e, flush_req}, 32'b01010);
        end
        check("stall_cnt", {16'd0, annul_cnt}, 32'd2);
        stall = 1'b0;
        bubble_d();
        step();
        check("stall_release_flags", {28'd0, flags_q}, 32'h3);
        alu_flags_e = 4'b1111;
        step();
        check("bubble_no_flag_update", {28'd0, flags_q}, 32'h3);
        check("bubble_no_count", {16'd0, annul_cnt}, 32'd2);

        // External flush together with stall: flush wins, no flag update
        drive(1'b1, 4'hE, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        flush = 1'b1; stall = 1'b1;
        step();
        flush = 1'b0; stall = 1'b0;
        check("flush_stall_bubble", {31'd0, cond_ex_e}, 32'd0);
        check("flush_stall_flags", {28'd0, flags_q}, 32'h3);
        alu_flags_e = 4'b0000;

        // Twenty never-conditions: narrow twin saturates, wide counter keeps counting
        drive(1'b1, 4'hF, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step();
        bubble_d();
        step();
        check("sat_small", {28'd0, s_annul_cnt}, 32'hF);
        check("sat_wide", {16'd0, annul_cnt}, 32'd22);
        check("never_no_flags", {28'd0, flags_q}, 32'h3);
        drive(1'b1, 4'hF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        bubble_d();
        step();
        check("sat_small_hold", {28'd0, s_annul_cnt}, 32'hF);
        check("sat_wide_more", {16'd0, annul_cnt}, 32'd23);

        // Asynchronous reset mid-cycle while an AL store/write is in E
        drive(1'b1, 4'hE, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        check("pre_reset_outs", {27'd0, pcsrc_e, regwrite_e, memwrite_e, cond_ex_e, flush_req}, 32'b11111);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outs", {27'd0, pcsrc_e, regwrite_e, memwrite_e, cond_ex_e, flush_req}, 32'h0);
        check("async_reset_state", {12'd0, flags_q, annul_cnt}, 32'h0);
        check("async_reset_small", {24'd0, s_flags_q, s_annul_cnt}, 32'h0);
        step();
        reset = 1'b0;
        drive(1'b1, 4'hE, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("reset_held_outs", {31'd0, regwrite_e}, 32'd0);
        step();
        check("first_capture", {31'd0, regwrite_e}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cond_stage.md
COND_STAGE -- requirements
Module: cond_stage

Interface
REQ-001 Parameter: CNT_W, default 16, width of the annulled-instruction counter.
REQ-002 Ports (name, direction, width, meaning); clock and reset are listed first:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  hold the E register and all state.
- flush  in  1  external kill; E loads a bubble.
- valid_d  in  1  decode stage holds a valid instruction.
- cond_d  in  4  condition field, instr[31:28].
- flagw_d  in  2  flag-write enables from the decoder; [1]=N,Z and [0]=C,V.
- pcs_d, regw_d, memw_d, nowrite_d  in  1 each  decoder control outputs.
- alu_flags_e  in  4  {N,Z,C,V} from the ALU for the E instruction.
- pcsrc_e, regwrite_e, memwrite_e  out  1 each  gated control outputs.
- cond_ex_e  out  1  E instruction is valid and its condition passes.
- flush_req  out  1  taken branch or PC write; upstream kills F/D.
- flags_q  out  4  architectural {N,Z,C,V}.
- annul_cnt  out  CNT_W  count of condition-failed instructions.

Function
REQ-003 E register fields: valid_e, cond_e, flagw_e, pcs_e, regw_e, memw_e, nowrite_e.
REQ-004 E register load priority at each clock edge:
- If flush or flush_req is asserted, load a bubble: valid_e=0 and all other fields 0.
- Else if stall is asserted, hold all fields.
- Else capture the *_d inputs, with valid_e=valid_d.
REQ-005 Condition check is combinational on flags_q and cond_e:
- 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
- 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
- 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V.
- 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1.
- 1111 is never (0).
REQ-006 cond_ex_e = valid_e & condition-check result.
REQ-007 Gated outputs:
- pcsrc_e = cond_ex_e & pcs_e.
- regwrite_e = cond_ex_e & regw_e & !nowrite_e.
- memwrite_e = cond_ex_e & memw_e.
- flush_req = pcsrc_e.
REQ-008 All outputs are combinational from registered state, with zero-cycle latency within E.
REQ-009 Flag update at a clock edge occurs only when stall=0 and cond_ex_e=1:
- flagw_e[1] → flags_q[3:2] <= alu_flags_e[3:2].
- flagw_e[0] → flags_q[1:0] <= alu_flags_e[1:0].
REQ-010 A flags_q update takes effect for the next instruction entering E; there is no same-cycle bypass.
REQ-011 When stall=1, flags_q and annul_cnt hold even if cond_ex_e=1. A stalled instruction never updates state twice.
REQ-012 annul_cnt increments by 1 at an edge with stall=0, valid_e=1 and cond_ex_e=0. It saturates at all-ones.
REQ-013 Bubbles (valid_e=0) never increment annul_cnt and never update flags_q.
REQ-014 Simultaneous flush and stall: flush wins, and E loads a bubble.
REQ-015 A taken branch (pcsrc_e=1) also updates flags_q if flagw_e is set and stall=0.
REQ-016 If stall and flush_req are asserted together: the E instruction completes its flag update only if stall=0; the bubble still loads.

Reset
REQ-017 While reset=1, and asynchronously on its assertion:
- valid_e=0 and all E fields are 0.
- flags_q=4'b0000 and annul_cnt=0.
- Consequently pcsrc_e, regwrite_e, memwrite_e, cond_ex_e and flush_req are 0.
REQ-018 Reset asserted mid-operation discards the E instruction without any flag or counter update. The first capture occurs at the first rising edge after deassertion.

Verification
REQ-019 Reset, then load AL ADDS (cond=1110, flagw=11, regw=1) with alu_flags_e=0100:
- Same cycle: regwrite_e=1.
- Next edge: flags_q=0100.
REQ-020 With flags_q=0100, load EQ STR (cond=0000, memw=1), then NE STR (0001):
- EQ STR: memwrite_e=1.
- NE STR: memwrite_e=0 and annul_cnt increments by 1.
REQ-021 CMP (flagw=11, nowrite=1, regw=1, cond=1110) with alu_flags_e=1000:
- regwrite_e=0.
- flags_q=1000 after the edge.
- A following LT instruction has cond_ex_e=1.
REQ-022 AL B (pcs=1):
- pcsrc_e=1 and flush_req=1.
- Next cycle valid_e=0 regardless of valid_d and stall.
REQ-023 Stall for 3 cycles with an ADDS held in E:
- flags_q updates exactly once, after stall drops.
- Outputs stay constant during the stall.
REQ-024 Counter and mid-op reset:
- Force annul_cnt to 16'hFFFF via repeated failing conditions; another failure holds it at 16'hFFFF.
- Assert reset asynchronously mid-cycle: all outputs become 0 immediately.
